// File: rtl/column_burst_decoder.sv
// column_burst_decoder: walks a one-hot SRAM column select across a linear or wrapping burst
module column_burst_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_COLS   = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  wrap_mode,
    input  logic                  step,
    output logic [NUM_COLS-1:0]   col_select,
    output logic [ADDR_WIDTH-1:0] col_addr,
    output logic                  col_valid,
    output logic                  last,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;
    localparam logic [ADDR_WIDTH-1:0] last_col = ADDR_WIDTH'(NUM_COLS - 1);
    state_t                state, state_n;
    logic [LEN_WIDTH-1:0]  count, count_n, mask, mask_n;
    logic                  wrap, wrap_n, err_pend, err_pend_n;
    logic [ADDR_WIDTH-1:0] addr_n, mask_a, wrap_addr, step_addr;
    logic                  in_range;
    assign start_ready = state == IDLE && !rst;
    assign in_range    = start_addr <= last_col;
    assign mask_a      = ADDR_WIDTH'(mask);
    assign wrap_addr   = (col_addr & ~mask_a) | (ADDR_WIDTH'(col_addr + 1'b1) & mask_a);
    assign step_addr   = wrap ? ADDR_WIDTH'(32'(wrap_addr) % NUM_COLS)
                              : (col_addr == last_col ? '0 : ADDR_WIDTH'(col_addr + 1'b1));
    // next-state: accept a request, advance one column per step, then one finish cycle
    always_comb begin
        state_n    = state;
        addr_n     = col_addr;
        count_n    = count;
        mask_n     = mask;
        wrap_n     = wrap;
        err_pend_n = err_pend;
        if (state == IDLE && start_valid) begin
            state_n    = in_range ? ACTIVE : FINISH;
            addr_n     = in_range ? start_addr : col_addr;
            count_n    = burst_len;
            mask_n     = burst_len;
            wrap_n     = wrap_mode;
            err_pend_n = !in_range;
        end else if (state == ACTIVE && step) begin
            state_n = count == '0 ? FINISH : ACTIVE;
            count_n = count == '0 ? count : count - 1'b1;
            addr_n  = count == '0 ? col_addr : step_addr;
        end else if (state == FINISH) begin
            state_n    = IDLE;
            err_pend_n = 1'b0;
        end
    end
    // state and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            col_addr   <= '0;
            count      <= '0;
            mask       <= '0;
            wrap       <= 1'b0;
            err_pend   <= 1'b0;
            col_select <= '0;
            col_valid  <= 1'b0;
            last       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            col_addr   <= addr_n;
            count      <= count_n;
            mask       <= mask_n;
            wrap       <= wrap_n;
            err_pend   <= err_pend_n;
            col_select <= state_n == ACTIVE ? NUM_COLS'(1) << addr_n : '0;
            col_valid  <= state_n == ACTIVE;
            last       <= state_n == ACTIVE && count_n == '0;
            done       <= state_n == FINISH;
            err        <= state_n == FINISH && err_pend_n;
        end
    end
endmodule

// File: tb/tb_column_burst_decoder.sv
// tb_column_burst_decoder: scoreboard bench for 16- and 12-column decoder instances
module tb_column_burst_decoder;
    typedef struct packed {
        logic [3:0] a;
        logic       l;
    } beat_t;
    logic        clk = 1'b0, rst = 1'b1, wrap_mode = 1'b0, step = 1'b0;
    logic [1:0]  sv = 2'b00;
    logic [3:0]  start_addr = '0, burst_len = '0;
    logic        rdy0, rdy1, cv0, cv1, last0, last1, done0, done1, err0, err1;
    logic [15:0] cs0;
    logic [11:0] cs1;
    logic [3:0]  ca0, ca1;
    logic        rdy, cv, lst, dn, er;
    logic [15:0] cs;
    logic [3:0]  ca;
    int          sel = 0, passed = 0, total = 0;
    beat_t       q[$];

    always #5 clk = ~clk;

    column_burst_decoder u0 (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(rdy0),
        .start_addr(start_addr), .burst_len(burst_len), .wrap_mode(wrap_mode), .step(step),
        .col_select(cs0), .col_addr(ca0), .col_valid(cv0), .last(last0), .done(done0), .err(err0)
    );

    column_burst_decoder #(.NUM_COLS(12)) u1 (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(rdy1),
        .start_addr(start_addr), .burst_len(burst_len), .wrap_mode(wrap_mode), .step(step),
        .col_select(cs1), .col_addr(ca1), .col_valid(cv1), .last(last1), .done(done1), .err(err1)
    );

    always_comb begin
        rdy = sel == 1 ? rdy1 : rdy0;
        cv  = sel == 1 ? cv1 : cv0;
        lst = sel == 1 ? last1 : last0;
        dn  = sel == 1 ? done1 : done0;
        er  = sel == 1 ? err1 : err0;
        cs  = sel == 1 ? {4'd0, cs1} : cs0;
        ca  = sel == 1 ? ca1 : ca0;
    end

    function automatic logic [3:0] adv(input logic [3:0] a, input logic [3:0] len, input logic w, input int n);
        logic [3:0] r;
        r = (a & ~len) | ((a + 4'd1) & len);
        if (w) return 4'(32'(r) % n);
        return (32'(a) == n - 1) ? 4'd0 : a + 4'd1;
    endfunction

    task automatic push_model(input logic [3:0] sa, input logic [3:0] len, input logic w, input int n);
        logic [3:0] a;
        a = sa;
        for (int i = 0; i <= int'(len); i++) begin
            q.push_back({a, i == int'(len)});
            a = adv(a, len, w, n);
        end
    endtask

    task automatic run(input int s, input logic [3:0] sa, input logic [3:0] len, input logic w,
                       input int gap, input logic exp_err);
        beat_t e;
        int    nv, ph, n, cyc;
        logic  fresh;
        n = q.size();
        sel = s;
        @(negedge clk);
        total++; if (rdy !== 1'b1) $display("FAIL ready_before: got %b want 1", rdy); else passed++;
        start_addr = sa; burst_len = len; wrap_mode = w; sv[s] = 1'b1;
        @(negedge clk);
        sv[s] = 1'b0; start_addr = ~sa; burst_len = ~len; wrap_mode = ~w;
        total++; if (rdy !== 1'b0) $display("FAIL ready_busy: got %b want 0", rdy); else passed++;
        nv = 0; ph = 0; cyc = 0; fresh = 1'b1; e = '0;
        while (cv === 1'b1 && cyc < 300) begin
            if (fresh) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL extra_beat: got addr %0d want no beat", ca);
                    break;
                end
                e = q.pop_front();
            end
            total++;
            if ({ca, cs, lst} !== {e.a, 16'd1 << e.a, e.l})
                $display("FAIL beat: got addr %0d sel %h last %b want addr %0d sel %h last %b",
                         ca, cs, lst, e.a, 16'd1 << e.a, e.l);
            else passed++;
            nv++;
            step = ph == gap - 1;
            ph = step ? 0 : ph + 1;
            fresh = step;
            @(negedge clk);
            cyc++;
        end
        step = 1'b0;
        total++; if (cyc >= 300) $display("FAIL timeout: got %0d cycles want < 300", cyc); else passed++;
        total++; if (q.size() != 0) $display("FAIL missing_beats: got %0d left want 0", q.size()); else passed++;
        total++; if (nv != n * gap) $display("FAIL valid_cycles: got %0d want %0d", nv, n * gap); else passed++;
        total++;
        if ({dn, er, cv, cs} !== {1'b1, exp_err, 1'b0, 16'd0})
            $display("FAIL finish: got done %b err %b valid %b sel %h want 1 %b 0 0000", dn, er, cv, cs, exp_err);
        else passed++;
        @(negedge clk);
        total++;
        if ({rdy, dn, er} !== 3'b100) $display("FAIL ready_after: got rdy/done/err %b want 100", {rdy, dn, er});
        else passed++;
        q.delete();
    endtask

    task automatic test_reset();
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({rdy, cv, lst, dn, er, cs, ca} !== '0)
                $display("FAIL reset_outputs: got rdy %b valid %b sel %h addr %0d done %b err %b want all 0",
                         rdy, cv, cs, ca, dn, er);
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (rdy !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", rdy); else passed++;
        for (int i = 0; i < 3; i++) begin
            step = i[0] == 1'b0;
            @(negedge clk);
            total++;
            if ({rdy, cv, dn, cs} !== {1'b1, 1'b0, 1'b0, 16'd0})
                $display("FAIL idle_step: got rdy %b valid %b done %b sel %h want 1 0 0 0000", rdy, cv, dn, cs);
            else passed++;
        end
        step = 1'b0;
    endtask

    task automatic test_linear();
        q.push_back({4'd14, 1'b0}); q.push_back({4'd15, 1'b0});
        q.push_back({4'd0, 1'b0});  q.push_back({4'd1, 1'b1});
        run(0, 4'd14, 4'd3, 1'b0, 1, 1'b0);
    endtask

    task automatic test_wrap();
        q.push_back({4'd6, 1'b0}); q.push_back({4'd7, 1'b0});
        q.push_back({4'd4, 1'b0}); q.push_back({4'd5, 1'b1});
        run(0, 4'd6, 4'd3, 1'b1, 1, 1'b0);
    endtask

    task automatic test_stall();
        q.push_back({4'd2, 1'b0}); q.push_back({4'd3, 1'b1});
        run(0, 4'd2, 4'd1, 1'b0, 3, 1'b0);
    endtask

    task automatic test_out_of_range();
        run(1, 4'd13, 4'd2, 1'b0, 1, 1'b1);
        run(1, 4'd12, 4'd0, 1'b1, 1, 1'b1);
        q.push_back({4'd11, 1'b0}); q.push_back({4'd0, 1'b1});
        run(1, 4'd11, 4'd1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_model();
        push_model(4'd10, 4'd3, 1'b0, 12);
        run(1, 4'd10, 4'd3, 1'b0, 1, 1'b0);
        push_model(4'd9, 4'd7, 1'b1, 12);
        run(1, 4'd9, 4'd7, 1'b1, 2, 1'b0);
        push_model(4'd10, 4'd4, 1'b1, 12);
        run(1, 4'd10, 4'd4, 1'b1, 1, 1'b0);
        push_model(4'd13, 4'd5, 1'b1, 16);
        run(0, 4'd13, 4'd5, 1'b1, 1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        sel = 0;
        @(negedge clk);
        start_addr = 4'd4; burst_len = 4'd7; wrap_mode = 1'b0; sv[0] = 1'b1; step = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({cv, ca} !== {1'b1, 4'(4 + i)})
                $display("FAIL mid_beat: got valid %b addr %0d want 1 %0d", cv, ca, 4 + i);
            else passed++;
            if (i < 2) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({rdy, cv, lst, dn, er, cs, ca} !== '0)
            $display("FAIL mid_reset: got valid %b sel %h addr %0d done %b rdy %b want all 0", cv, cs, ca, dn, rdy);
        else passed++;
        rst = 1'b0; step = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy, dn, er, cv} !== 4'b1000) $display("FAIL post_reset: got rdy/done/err/valid %b want 1000", {rdy, dn, er, cv});
        else passed++;
        q.push_back({4'd9, 1'b1});
        run(0, 4'd9, 4'd0, 1'b0, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_linear();
        test_wrap();
        test_stall();
        test_out_of_range();
        test_model();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/column_burst_decoder.md
# column_burst_decoder

Sequenced successor to the combinational column decoder. It accepts a burst request (start column, length, linear or wrapping order) through a valid/ready handshake. It then walks the SRAM column one-hot select across the burst, one column per `step`, and reports progress through `col_valid`, `last` and a `done` pulse. The block sits between the SRAM access controller (which drives `step` once per column read/write) and the column mux/sense-amp select lines.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: column address width.
- `NUM_COLS`, 16: number of physical columns; must satisfy 2 ≤ NUM_COLS ≤ 2**ADDR_WIDTH.
- `LEN_WIDTH`, 4: burst-length field width; burst length = `burst_len`+1 (1..2**LEN_WIDTH).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  burst request present.
- `start_ready`  out  1  block can accept a request.
- `start_addr`  in  ADDR_WIDTH  first column of burst.
- `burst_len`  in  LEN_WIDTH  burst length minus one.
- `wrap_mode`  in  1  0 = linear, 1 = wrapping.
- `step`  in  1  advance to next column (honoured only while `col_valid`).
- `col_select`  out  NUM_COLS  registered one-hot column select, zero when idle.
- `col_addr`  out  ADDR_WIDTH  current column index.
- `col_valid`  out  1  `col_select` is driving a burst column.
- `last`  out  1  current column is the final beat of the burst.
- `done`  out  1  one-cycle pulse after final beat is consumed.
- `err`  out  1  one-cycle pulse, coincident with `done`, for a rejected request.

## Operation
- States: IDLE, ACTIVE, FINISH.
- IDLE: `start_ready`=1. On `start_valid`&&`start_ready`, capture `start_addr`, `burst_len` into count, and `wrap_mode`.
  - If `start_addr` < NUM_COLS: go to ACTIVE.
  - Otherwise: go to FINISH with err pending, with no column ever driven.
- ACTIVE: `col_valid`=1; `col_select` = one-hot of `col_addr`; `last` = (count==0).
  - On `step` with count==0: go to FINISH.
  - On `step` with count>0: decrement count and advance the address.
  - Without `step`: hold everything.
- Linear advance: `col_addr`+1, wrapping NUM_COLS-1 → 0 (modulo NUM_COLS; NUM_COLS need not be a power of two).
- Wrap advance: mask = `burst_len` zero-extended. New addr = (addr & ~mask) | ((addr+1) & mask). This equals an aligned wrapping burst when length is a power of two.
  - For any length, the wrapping result is computed by the same formula.
  - A wrapped result ≥ NUM_COLS is reduced modulo NUM_COLS.
- FINISH: outputs `done`=1 (and `err`=1 if pending) for exactly one cycle. `col_select`=0, `col_valid`=0, `start_ready`=0. Always returns to IDLE next cycle.
- `start_valid` outside IDLE is ignored (not queued). `step` outside ACTIVE is ignored.
- `burst_len` and `wrap_mode` are sampled only at acceptance; later changes have no effect.

## Timing
- Reset values, and values while `rst`=1: state IDLE; `col_select`=0, `col_addr`=0, `col_valid`=0, `last`=0, `done`=0, `err`=0, `start_ready`=0.
- `start_ready`=1 from the first cycle after `rst` deasserts.
- Acceptance at edge N: `col_valid`/`col_select` valid from cycle N+1 (1-cycle latency). `start_ready` is low from N+1.
- Each `step` sampled high at an ACTIVE edge moves to the next column at the following cycle. Back-to-back steps give one column per cycle.
- A burst of L beats with `step` held high: `col_valid` for L cycles, `done` on cycle N+L+1, `start_ready` again on N+L+2.
- `err` path: `done`/`err` on cycle N+1, ready on N+2.
- `rst` during ACTIVE or FINISH: IDLE at the next edge, all outputs zeroed, no `done`/`err` emitted.
- `col_select`, `col_addr`, `col_valid`, `last`, `done` and `err` are registered outputs. `start_ready` may be decoded from state and `rst`.

## Test plan
- Reset then idle: hold `rst` 3 cycles, release → all outputs 0 during reset, `start_ready`=1 on first cycle after release, `step` pulses produce no change.
- Linear burst: `start_addr`=14, `burst_len`=3, `wrap_mode`=0, `step` held high → `col_addr` 14,15,0,1; `col_select` 0x4000,0x8000,0x0001,0x0002; `last` only on addr 1; `done` one cycle after.
- Wrap burst: `start_addr`=6, `burst_len`=3, `wrap_mode`=1 → `col_addr` 6,7,4,5, then `done`; `err`=0.
- Stalled steps: `start_addr`=2, `burst_len`=1, `step` pulsed every third cycle → `col_addr` 2 held until first step, then 3 with `last`=1 held until second step, then `done`. Total `col_valid` duration matches the step spacing.
- Out-of-range with NUM_COLS=12: `start_addr`=13 → `col_valid` never asserted, `done`=`err`=1 on the cycle after accept, ready after that.
- Reset mid-burst: `burst_len`=7, assert `rst` after 3 beats → next cycle all outputs 0, no `done`. A new request after release starts cleanly at its own `start_addr`.
